// File: rtl/cpu_bus_initiator.sv
// Bus-cycle sequencer for an 8088-style chipset: runs T1/T2/T3/TW/T4 cycles
// with wait states, a wait-state timeout, halt cycles and the paired INTA sequence.
//
// state | meaning
// IDLE  | bus passive; accepts a request, or counts the two-clock gap between INTA cycles
// T1    | status and address driven for the registered request
// T2    | status still driven; halt skips straight to T4 from here
// T3    | first processor_ready sample
// TW    | wait state; counts waits until ready or timeout
// T4    | completion clock; rsp_valid pulses unless this ends the first INTA cycle
module cpu_bus_initiator #(
    parameter int unsigned TIMEOUT_WAITS = 1023
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [2:0]  req_type,
    input  logic        req_lock,
    input  logic [19:0] req_address,
    input  logic [7:0]  req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [2:0]  processor_status,
    output logic        processor_lock_n,
    output logic [19:0] cpu_address,
    output logic [7:0]  cpu_data_bus,
    input  logic [7:0]  cpu_data_in,
    input  logic        processor_ready
);

    typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

    localparam logic [2:0] TYPE_INTA      = 3'b000;
    localparam logic [2:0] TYPE_IO_WR     = 3'b010;
    localparam logic [2:0] TYPE_HALT      = 3'b011;
    localparam logic [2:0] TYPE_MEM_WR    = 3'b110;
    localparam logic [2:0] TYPE_ILLEGAL   = 3'b111;
    localparam logic [2:0] STATUS_PASSIVE = 3'b111;
    localparam logic [9:0] WAIT_LIMIT     = 10'((TIMEOUT_WAITS > 1023) ? 1023 : TIMEOUT_WAITS);

    state_t      state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic        lock_q, lock_d;
    logic [19:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        timeout_q, timeout_d;
    logic [9:0]  wait_cnt_q, wait_cnt_d;
    logic        inta_second_q, inta_second_d;
    logic        gap_q, gap_d;
    logic        ready_en_q, ready_en_d;

    logic is_write, is_read, final_cycle, bus_active, accept, end_ok, end_to;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            type_q        <= STATUS_PASSIVE;
            lock_q        <= 1'b0;
            addr_q        <= 20'h0_0000;
            wdata_q       <= 8'h00;
            rdata_q       <= 8'h00;
            timeout_q     <= 1'b0;
            wait_cnt_q    <= 10'd0;
            inta_second_q <= 1'b0;
            gap_q         <= 1'b0;
            ready_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            lock_q        <= lock_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            timeout_q     <= timeout_d;
            wait_cnt_q    <= wait_cnt_d;
            inta_second_q <= inta_second_d;
            gap_q         <= gap_d;
            ready_en_q    <= ready_en_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        lock_d        = lock_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        timeout_d     = timeout_q;
        wait_cnt_d    = wait_cnt_q;
        inta_second_d = inta_second_q;
        gap_d         = gap_q;
        ready_en_d    = 1'b1;
        end_ok        = 1'b0;
        end_to        = 1'b0;

        is_write    = (type_q == TYPE_IO_WR) || (type_q == TYPE_MEM_WR);
        is_read     = type_q inside {3'b000, 3'b001, 3'b100, 3'b101};
        // A timeout on the first INTA cycle ends the whole sequence.
        final_cycle = timeout_q || !((type_q == TYPE_INTA) && !inta_second_q);
        bus_active  = (state_q != IDLE);
        req_ready   = ready_en_q && (((state_q == IDLE) && !inta_second_q) ||
                                     ((state_q == T4) && final_cycle));
        accept      = req_ready && req_valid && (req_type != TYPE_ILLEGAL);

        case (state_q)
            IDLE: begin
                if (inta_second_q) begin
                    gap_d = ~gap_q;
                    if (gap_q) state_d = T1;
                end else if (accept) begin
                    state_d = T1;
                end
            end
            T1: begin
                wait_cnt_d = 10'd0;
                state_d    = T2;
            end
            T2: begin
                if (type_q == TYPE_HALT) begin
                    end_ok  = 1'b1;
                    state_d = T4;
                end else begin
                    state_d = T3;
                end
            end
            T3: begin
                if (processor_ready) begin
                    end_ok  = 1'b1;
                    state_d = T4;
                end else if (WAIT_LIMIT == 10'd0) begin
                    end_to  = 1'b1;
                    state_d = T4;
                end else begin
                    wait_cnt_d = 10'd1;
                    state_d    = TW;
                end
            end
            TW: begin
                if (processor_ready) begin
                    end_ok  = 1'b1;
                    state_d = T4;
                end else if (wait_cnt_q >= WAIT_LIMIT) begin
                    end_to  = 1'b1;
                    state_d = T4;
                end else if (wait_cnt_q != 10'h3FF) begin
                    wait_cnt_d = wait_cnt_q + 10'd1;
                end
            end
            T4: begin
                if (final_cycle) begin
                    inta_second_d = 1'b0;
                    state_d       = accept ? T1 : IDLE;
                end else begin
                    inta_second_d = 1'b1;
                    gap_d         = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            type_d  = req_type;
            lock_d  = req_lock;
            addr_d  = req_address;
            wdata_d = req_wdata;
        end

        if (end_ok) begin
            rdata_d   = is_read ? cpu_data_in : 8'h00;
            timeout_d = 1'b0;
        end
        if (end_to) begin
            rdata_d   = 8'hFF;
            timeout_d = 1'b1;
        end

        rsp_valid        = (state_q == T4) && final_cycle;
        rsp_rdata        = rdata_q;
        rsp_timeout      = timeout_q;
        processor_status = ((state_q == T1) || (state_q == T2)) ? type_q : STATUS_PASSIVE;
        processor_lock_n = !(lock_q && (bus_active || inta_second_q));
        cpu_address      = addr_q;
        cpu_data_bus     = (bus_active && is_write) ? wdata_q : 8'h00;
    end

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Directed scoreboard bench for cpu_bus_initiator: expected responses are queued
// at issue time and a forked monitor checks them whenever rsp_valid pulses.
module tb_cpu_bus_initiator;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid;
    logic [2:0]  req_type;
    logic        req_lock;
    logic [19:0] req_address;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic [2:0]  processor_status;
    logic        processor_lock_n;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_data_bus;
    logic [7:0]  cpu_data_in;
    logic        processor_ready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       to;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    cpu_bus_initiator #(.TIMEOUT_WAITS(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_type         (req_type),
        .req_lock         (req_lock),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_timeout      (rsp_timeout),
        .processor_status (processor_status),
        .processor_lock_n (processor_lock_n),
        .cpu_address      (cpu_address),
        .cpu_data_bus     (cpu_data_bus),
        .cpu_data_in      (cpu_data_in),
        .processor_ready  (processor_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=rsp_valid required=none (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, e.rdata});
                    chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.to});
                end
            end
        end
    endtask

    // Issue at a negedge; the next posedge accepts, so we return positioned in T1.
    task automatic start_req(input logic [2:0] t, input logic l, input logic [19:0] a,
                             input logic [7:0] w, input bit expect_rsp,
                             input logic [7:0] exp_rd, input logic exp_to, input int lat);
        chk("req_ready_at_issue", {31'h0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_type    = t;
        req_lock    = l;
        req_address = a;
        req_wdata   = w;
        if (expect_rsp) exp_q.push_back('{exp_rd, exp_to, cyc + lat});
        tick();
        req_valid = 1'b0;
    endtask

    logic [7:0] fetch_data [3];

    initial begin
        req_valid       = 1'b0;
        req_type        = 3'b000;
        req_lock        = 1'b0;
        req_address     = 20'h0;
        req_wdata       = 8'h00;
        cpu_data_in     = 8'h00;
        processor_ready = 1'b1;
        fetch_data[0]   = 8'hA1;
        fetch_data[1]   = 8'hA2;
        fetch_data[2]   = 8'hA3;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) tick();
        chk("rst_status", {29'h0, processor_status}, 32'h7);
        chk("rst_lock_n", {31'h0, processor_lock_n}, 32'h1);
        chk("rst_address", {12'h0, cpu_address}, 32'h0);
        chk("rst_data_bus", {24'h0, cpu_data_bus}, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        reset_n = 1'b1;
        chk("req_ready_before_first_edge", {31'h0, req_ready}, 32'h0);
        tick();
        chk("req_ready_after_reset", {31'h0, req_ready}, 32'h1);

        // Illegal type is ignored
        req_valid = 1'b1;
        req_type  = 3'b111;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("illegal_status", {29'h0, processor_status}, 32'h7);
            chk("illegal_ready", {31'h0, req_ready}, 32'h1);
        end
        req_valid = 1'b0;
        tick();

        // Mem read, zero waits
        cpu_data_in     = 8'hEA;
        processor_ready = 1'b1;
        start_req(3'b101, 1'b0, 20'hF0000, 8'h00, 1'b1, 8'hEA, 1'b0, 4);
        chk("mrd_t1_status", {29'h0, processor_status}, 32'h5);
        chk("mrd_t1_address", {12'h0, cpu_address}, 32'hF0000);
        chk("mrd_t1_lock_n", {31'h0, processor_lock_n}, 32'h1);
        chk("mrd_t1_data_bus", {24'h0, cpu_data_bus}, 32'h0);
        chk("mrd_t1_ready", {31'h0, req_ready}, 32'h0);
        tick();
        chk("mrd_t2_status", {29'h0, processor_status}, 32'h5);
        tick();
        chk("mrd_t3_status", {29'h0, processor_status}, 32'h7);
        tick();
        chk("mrd_t4_ready", {31'h0, req_ready}, 32'h1);
        tick();

        // IO write with three wait states
        processor_ready = 1'b0;
        start_req(3'b010, 1'b0, 20'h003D8, 8'h29, 1'b1, 8'h00, 1'b0, 7);
        chk("iowr_t1_status", {29'h0, processor_status}, 32'h2);
        for (int k = 1; k <= 7; k++) begin
            chk("iowr_data_bus", {24'h0, cpu_data_bus}, 32'h29);
            if (k == 6) processor_ready = 1'b1;
            if (k < 7) tick();
        end
        tick();
        chk("iowr_idle_data_bus", {24'h0, cpu_data_bus}, 32'h0);

        // Halt ignores processor_ready
        processor_ready = 1'b0;
        start_req(3'b011, 1'b0, 20'h00000, 8'h00, 1'b1, 8'h00, 1'b0, 3);
        chk("halt_t1_status", {29'h0, processor_status}, 32'h3);
        tick();
        chk("halt_t2_status", {29'h0, processor_status}, 32'h3);
        tick();
        chk("halt_t4_status", {29'h0, processor_status}, 32'h7);
        tick();

        // Locked INTA pair
        processor_ready = 1'b1;
        cpu_data_in     = 8'h55;
        start_req(3'b000, 1'b1, 20'h00000, 8'h00, 1'b1, 8'h08, 1'b0, 10);
        for (int k = 1; k <= 10; k++) begin
            chk("inta_lock_n", {31'h0, processor_lock_n}, 32'h0);
            chk("inta_status", {29'h0, processor_status},
                (k == 1 || k == 2 || k == 7 || k == 8) ? 32'h0 : 32'h7);
            chk("inta_req_ready", {31'h0, req_ready}, (k == 10) ? 32'h1 : 32'h0);
            if (k == 5) cpu_data_in = 8'h08;
            if (k < 10) tick();
        end
        tick();
        chk("inta_lock_released", {31'h0, processor_lock_n}, 32'h1);

        // Timeout after four waits
        processor_ready = 1'b0;
        start_req(3'b101, 1'b0, 20'hF0000, 8'h00, 1'b1, 8'hFF, 1'b1, 8);
        repeat (8) tick();
        chk("timeout_idle_status", {29'h0, processor_status}, 32'h7);

        // Reset during a wait state
        start_req(3'b110, 1'b1, 20'h2ABCD, 8'h5A, 1'b0, 8'h00, 1'b0, 0);
        repeat (4) tick();
        chk("pre_rst_lock_n", {31'h0, processor_lock_n}, 32'h0);
        chk("pre_rst_data_bus", {24'h0, cpu_data_bus}, 32'h5A);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_status", {29'h0, processor_status}, 32'h7);
        chk("mid_rst_lock_n", {31'h0, processor_lock_n}, 32'h1);
        chk("mid_rst_address", {12'h0, cpu_address}, 32'h0);
        chk("mid_rst_data_bus", {24'h0, cpu_data_bus}, 32'h0);
        chk("mid_rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("mid_rst_rsp_rdata", {24'h0, rsp_rdata}, 32'h0);
        chk("mid_rst_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        processor_ready = 1'b1;
        cpu_data_in     = 8'h3C;
        start_req(3'b101, 1'b0, 20'h00123, 8'h00, 1'b1, 8'h3C, 1'b0, 4);
        chk("post_rst_address", {12'h0, cpu_address}, 32'h00123);
        repeat (4) tick();

        // Back-to-back fetches with req_valid held
        for (int i = 0; i < 3; i++) begin
            chk("b2b_ready", {31'h0, req_ready}, 32'h1);
            req_valid   = 1'b1;
            req_type    = 3'b100;
            req_lock    = 1'b0;
            req_address = 20'h10000 + 20'(i);
            cpu_data_in = fetch_data[i];
            exp_q.push_back('{fetch_data[i], 1'b0, cyc + 4});
            tick();
            chk("b2b_t1_status", {29'h0, processor_status}, 32'h4);
            chk("b2b_t1_address", {12'h0, cpu_address}, 32'h10000 + i);
            repeat (3) tick();
        end
        req_valid = 1'b0;
        tick();

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
